seq_divider: RTL and testbench

- Iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor. Produces quotient and remainder; one quotient bit per cycle.
- Inverse companion to the 8x8 sequential array multiplier. Shares its clock/reset domain and operand widths.
- Used by downstream datapath logic to undo or scale multiplier products.
- Start/ready request side, single-cycle valid pulse on completion.

---
 rtl/seq_div_pkg.sv | 19 +
 rtl/seq_divider_div_step.sv | 21 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Counter must hold 2*WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // WIDTH+1 bit compare: the shifted value may exceed any WIDTH-bit divisor.
    assign shifted   = {prem, bit_in};
    assign diff      = shifted - {1'b0, divisor};
    assign q_bit     = shifted >= {1'b0, divisor};
    assign prem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle.
// Optional early exit for trivial operands: SEQ_DIVIDER_EARLY_EXIT_EN.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               ready,
    output logic               valid,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   prem;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic               last;
    logic               early;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .bit_in    (work[2*WIDTH-1]),
        .divisor   (dvsr),
        .prem_next (step_rem),
        .q_bit     (step_q)
    );

    assign last = (count == CW'(1));

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign early = (divisor == '0) ||
                   (dividend < {{WIDTH{1'b0}}, divisor});
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start)
                    state_nxt = early ? DONE : RUN;
            end
            RUN: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                valid     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            work        <= '0;
            dvsr        <= '0;
            prem        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work  <= dividend;
                        dvsr  <= divisor;
                        prem  <= '0;
                        count <= CW'(2 * WIDTH);
                        if (early) begin
                            quotient    <= (divisor == '0) ? '1 : '0;
                            remainder   <= dividend[WIDTH-1:0];
                            div_by_zero <= (divisor == '0);
                        end
                    end
                end
                RUN: begin
                    // work doubles as quotient accumulator as dividend bits leave
                    prem  <= step_rem;
                    work  <= {work[2*WIDTH-2:0], step_q};
                    count <= count - CW'(1);
                    if (last) begin
                        quotient    <= {work[2*WIDTH-2:0], step_q};
                        remainder   <= step_rem;
                        div_by_zero <= (dvsr == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        ready;
    logic        valid;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full operation: wait for ready, accept, track latency, check results.
    task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                         input bit hold, input bit disturb);
        logic [15:0] exp_q;
        logic [7:0]  exp_r;
        int          exp_lat;
        int          k;
        int          w;
        exp_q   = (dv == 0) ? 16'hFFFF : dd / {8'd0, dv};
        exp_r   = (dv == 0) ? dd[7:0] : 8'(dd % {8'd0, dv});
        exp_lat = 16;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
        if (dv == 0 || dd < {8'd0, dv})
            exp_lat = 0;
`endif
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold)
            start = 1'b0;
        k = 0;
        while (!valid && k < 40) begin
            check("ready_busy", {31'd0, ready}, 32'd0);
            if (disturb && k == 5) begin
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
                start    = 1'b1;
            end
            if (disturb && k == 6)
                start = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("quotient", {16'd0, quotient}, {16'd0, exp_q});
        check("remainder", {24'd0, remainder}, {24'd0, exp_r});
        check("dbz", {31'd0, div_by_zero}, {31'd0, dv == 0});
        @(posedge clk);
        #1;
        check("valid_width", {31'd0, valid}, 32'd0);
        check("ready_back", {31'd0, ready}, 32'd1);
        // Results hold after completion
        check("q_hold", {16'd0, quotient}, {16'd0, exp_q});
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  rv;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(16'd30000, 8'd200, 1'b0, 1'b0);
        do_op(16'd1000, 8'd7, 1'b1, 1'b0);
        do_op(16'd65535, 8'd255, 1'b0, 1'b0);
        do_op(16'd1234, 8'd0, 1'b0, 1'b0);
        do_op(16'd100, 8'd200, 1'b0, 1'b0);
        do_op(16'd5000, 8'd3, 1'b0, 1'b1);

        // Abort a run with reset partway through
        @(negedge clk);
        dividend = 16'd5000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("abort_novalid", {31'd0, valid}, 32'd0);
        end
        reset = 1'b0;
        #1;
        check("abort_q", {16'd0, quotient}, 32'd0);
        check("abort_r", {24'd0, remainder}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", {30'd0, valid, ready}, 32'd1);
        end
        do_op(16'd50, 8'd7, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rd = 16'($urandom);
            rv = 8'($urandom);
            if (i % 6 == 0) rv = 8'd0;
            if (i % 6 == 1) rd = 16'($urandom_range(0, 300));
            if (i % 6 == 2) rv = 8'($urandom_range(1, 3));
            do_op(rd, rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
